sync_fifo_flags: RTL and testbench

Single-clock FIFO with arbitrary (non-power-of-two) depth and an occupancy count. Provides programmable almost-full and almost-empty flags, sticky overflow and underflow error flags, and a selectable standard or first-word-fall-through (FWFT) read mode. It replaces the dual-clock FIFO in same-clock-domain datapaths, where gray-code synchronisation is unnecessary and watermark flags are needed for flow control.

---
 rtl/sync_fifo_flags.sv | 136 +++++++++++++
 tb/tb_sync_fifo_flags.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO of arbitrary depth with an occupancy count.
// It provides almost-full and almost-empty watermarks, sticky overflow and
// underflow flags, and either registered (standard) or first-word-fall-through
// read data.

module sync_fifo_flags #(
    parameter int DEPTH      = 12,
    parameter int DATA_WIDTH = 8,
    parameter int FWFT       = 0,
    parameter int AF_THRESH  = 10,
    parameter int AE_THRESH  = 2,
    localparam int CW        = $clog2(DEPTH + 1),
    localparam int PW        = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_wr,
    input  logic                  wr_en,
    output logic                  fifo_full,
    output logic [DATA_WIDTH-1:0] data_rd,
    input  logic                  rd_en,
    output logic                  fifo_empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [CW-1:0]         count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  err_clr
);

    // Reject illegal parameter combinations at elaboration time.
    if (DEPTH < 2 || DATA_WIDTH < 1 || (FWFT != 0 && FWFT != 1) ||
        AF_THRESH < 1 || AF_THRESH > DEPTH ||
        AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_params
        $error("sync_fifo_flags: illegal parameter value");
    end

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic [CW-1:0]         w_count_nxt;
    logic                  r_overflow;
    logic                  r_underflow;
    logic                  w_wr_acc;
    logic                  w_rd_acc;

    // Flags decode the registered count only, so they move one cycle after
    // the edge that accepted the request.
    assign fifo_full    = (r_count == CW'(DEPTH));
    assign fifo_empty   = (r_count == '0);
    assign almost_full  = (r_count >= CW'(AF_THRESH));
    assign almost_empty = (r_count <= CW'(AE_THRESH));
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    // Acceptance looks at registered state, never at the other request.
    assign w_wr_acc = wr_en & ~fifo_full;
    assign w_rd_acc = rd_en & ~fifo_empty;

    // Next occupancy: simultaneous accepted read and write cancel out.
    always_comb begin
        // NOTE: default assigned first so every path drives the signal and no latch is inferred.
        w_count_nxt = r_count;
        case ({w_wr_acc, w_rd_acc})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    // Storage write port.
    always_ff @(posedge clk) begin
        // NOTE: the array is deliberately not reset; pointers and count define validity.
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= data_wr;
        end
    end

    // Pointers and count, wrapping at DEPTH-1 since DEPTH need not be 2^n.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments to avoid simulation races.
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            end
            r_count <= w_count_nxt;
        end
    end

    // Sticky error flags; a set event in the same cycle as err_clr wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (wr_en && fifo_full) begin
                r_overflow <= 1'b1;
            end else if (err_clr) begin
                r_overflow <= 1'b0;
            end
            if (rd_en && fifo_empty) begin
                r_underflow <= 1'b1;
            end else if (err_clr) begin
                r_underflow <= 1'b0;
            end
        end
    end

    if (FWFT != 0) begin : g_fwft
        // Head of the queue is presented directly; zero while empty.
        assign data_rd = fifo_empty ? '0 : r_mem[r_rd_ptr];
    end else begin : g_std
        logic [DATA_WIDTH-1:0] r_data_rd;

        // Registered read data, held until the next accepted read.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_data_rd <= '0;
            end else if (w_rd_acc) begin
                r_data_rd <= r_mem[r_rd_ptr];
            end
        end

        assign data_rd = r_data_rd;
    end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed testbench for sync_fifo_flags: one standard-mode and one FWFT-mode
// instance, both DEPTH=12, AF_THRESH=10, AE_THRESH=2.

module tb_sync_fifo_flags;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Standard-mode instance signals.
    logic       s_rst = 1'b1, s_wr_en = 1'b0, s_rd_en = 1'b0, s_err_clr = 1'b0;
    logic [7:0] s_data_wr = '0, s_data_rd;
    logic       s_full, s_empty, s_af, s_ae, s_ov, s_uf;
    logic [3:0] s_count;

    // FWFT-mode instance signals.
    logic       f_rst = 1'b1, f_wr_en = 1'b0, f_rd_en = 1'b0, f_err_clr = 1'b0;
    logic [7:0] f_data_wr = '0, f_data_rd;
    logic       f_full, f_empty, f_af, f_ae, f_ov, f_uf;
    logic [3:0] f_count;

    sync_fifo_flags #(.DEPTH(12), .DATA_WIDTH(8), .FWFT(0), .AF_THRESH(10), .AE_THRESH(2)) u_std (
        .clk(clk), .rst(s_rst), .data_wr(s_data_wr), .wr_en(s_wr_en), .fifo_full(s_full),
        .data_rd(s_data_rd), .rd_en(s_rd_en), .fifo_empty(s_empty), .almost_full(s_af),
        .almost_empty(s_ae), .count(s_count), .overflow(s_ov), .underflow(s_uf),
        .err_clr(s_err_clr)
    );

    sync_fifo_flags #(.DEPTH(12), .DATA_WIDTH(8), .FWFT(1), .AF_THRESH(10), .AE_THRESH(2)) u_fwft (
        .clk(clk), .rst(f_rst), .data_wr(f_data_wr), .wr_en(f_wr_en), .fifo_full(f_full),
        .data_rd(f_data_rd), .rd_en(f_rd_en), .fifo_empty(f_empty), .almost_full(f_af),
        .almost_empty(f_ae), .count(f_count), .overflow(f_ov), .underflow(f_uf),
        .err_clr(f_err_clr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] q[$];
    logic [7:0] exp_b;

    initial begin
        // ---------------- reset both instances ----------------
        step();
        s_rst = 1'b0;
        f_rst = 1'b0;
        check("rst_empty", s_empty, 1);
        check("rst_ae", s_ae, 1);
        check("rst_count", s_count, 0);
        check("rst_full", s_full, 0);
        check("rst_af", s_af, 0);
        check("rst_ov", s_ov, 0);
        check("rst_uf", s_uf, 0);
        check("rst_data", s_data_rd, 0);

        // ---------------- fill 0x01..0x0C ----------------
        s_wr_en = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            s_data_wr = 8'(i);
            step();
            check("fill_count", s_count, i);
            check("fill_af", s_af, (i >= 10));
            check("fill_full", s_full, (i == 12));
            check("fill_ae", s_ae, (i <= 2));
        end
        s_wr_en = 1'b0;

        // ---------------- drain, latency 1 ----------------
        s_rd_en = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step();
            check("drain_data", s_data_rd, i);
            check("drain_count", s_count, 12 - i);
        end
        s_rd_en = 1'b0;
        check("drain_empty", s_empty, 1);
        step();
        check("drain_hold", s_data_rd, 8'h0C);

        // ---------------- wrap-around ----------------
        s_wr_en = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            s_data_wr = 8'(i);
            step();
        end
        s_wr_en = 1'b0;
        check("wrap_count12", s_count, 12);
        s_rd_en = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            check("wrap_rd5", s_data_rd, i);
        end
        s_rd_en = 1'b0;
        check("wrap_count7", s_count, 7);
        s_wr_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_data_wr = 8'hA0 + 8'(i);
            step();
        end
        s_wr_en = 1'b0;
        check("wrap_count12b", s_count, 12);
        s_rd_en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            exp_b = (i < 7) ? 8'h06 + 8'(i) : 8'hA0 + 8'(i - 7);
            step();
            check("wrap_data", s_data_rd, exp_b);
        end
        s_rd_en = 1'b0;
        check("wrap_count0", s_count, 0);

        // ---------------- full with read+write ----------------
        s_wr_en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            s_data_wr = 8'h10 + 8'(i);
            step();
        end
        s_data_wr = 8'hEE;
        s_rd_en = 1'b1;
        step();
        s_wr_en = 1'b0;
        s_rd_en = 1'b0;
        check("full_rw_data", s_data_rd, 8'h10);
        check("full_rw_count", s_count, 11);
        check("full_rw_ov", s_ov, 1);
        check("full_rw_uf", s_uf, 0);
        s_err_clr = 1'b1;
        step();
        s_err_clr = 1'b0;
        check("ov_clr", s_ov, 0);
        s_rd_en = 1'b1;
        for (int i = 1; i < 12; i++) begin
            step();
            check("full_rw_drain", s_data_rd, 8'h10 + 8'(i));
        end
        s_rd_en = 1'b0;
        check("full_rw_empty", s_empty, 1);

        // ---------------- empty with read+write ----------------
        s_wr_en = 1'b1;
        s_rd_en = 1'b1;
        s_data_wr = 8'h77;
        step();
        s_rd_en = 1'b0;
        check("empty_rw_count", s_count, 1);
        check("empty_rw_uf", s_uf, 1);
        check("empty_rw_hold", s_data_rd, 8'h1B);
        q.push_back(8'h77);
        for (int i = 0; i < 4; i++) begin
            s_data_wr = 8'h78 + 8'(i);
            q.push_back(s_data_wr);
            step();
        end
        check("steady_count_start", s_count, 5);

        // ---------------- steady state at count 5 ----------------
        s_rd_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            s_data_wr = 8'h80 + 8'(i);
            q.push_back(s_data_wr);
            exp_b = q.pop_front();
            step();
            check("steady_count", s_count, 5);
            check("steady_data", s_data_rd, exp_b);
        end
        s_wr_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            exp_b = q.pop_front();
            step();
            check("steady_drain", s_data_rd, exp_b);
        end
        s_rd_en = 1'b0;
        check("steady_empty", s_empty, 1);

        // ---------------- underflow clear, then set beats clear ----------------
        s_err_clr = 1'b1;
        step();
        check("uf_clr", s_uf, 0);
        s_rd_en = 1'b1;
        step();
        s_rd_en = 1'b0;
        s_err_clr = 1'b0;
        check("uf_set_wins", s_uf, 1);
        check("uf_count", s_count, 0);

        // ---------------- FWFT mode ----------------
        check("fwft_rst_data", f_data_rd, 0);
        check("fwft_rst_empty", f_empty, 1);
        f_wr_en = 1'b1;
        f_data_wr = 8'h55;
        step();
        f_wr_en = 1'b0;
        check("fwft_first_data", f_data_rd, 8'h55);
        check("fwft_first_empty", f_empty, 0);
        check("fwft_first_count", f_count, 1);
        f_rd_en = 1'b1;
        step();
        f_rd_en = 1'b0;
        check("fwft_pop_empty", f_empty, 1);
        check("fwft_pop_data", f_data_rd, 0);
        f_wr_en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            f_data_wr = 8'h60 + 8'(i);
            step();
            check("fwft_head", f_data_rd, 8'h60);
        end
        f_wr_en = 1'b0;
        check("fwft_count7", f_count, 7);
        f_rd_en = 1'b1;
        step();
        f_rd_en = 1'b0;
        check("fwft_next", f_data_rd, 8'h61);
        f_rst = 1'b1;
        step();
        f_rst = 1'b0;
        check("fwft_rst_count", f_count, 0);
        check("fwft_rst_empty2", f_empty, 1);
        check("fwft_rst_data2", f_data_rd, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
